// File: rtl/imem_loader.sv
// Instruction-memory program loader: streams a program into a 1R1W instruction memory,
// stalls the core while loading, then passes core fetches straight through to memory.
module imem_loader #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_start,
   input  logic [AW:0]   load_len,
   input  logic          load_valid,
   input  logic [31:0]   load_data,
   output logic          load_ready,
   output logic          load_done,
   output logic [31:0]   load_csum,
   output logic          core_stall,
   input  logic [31:0]   fetch_addr,
   output logic [31:0]   fetch_instr,
   output logic          fetch_valid,
   output logic [31:0]   mem_rd_addr,
   output logic [31:0]   mem_wr_addr,
   output logic [31:0]   mem_wr_din,
   output logic          mem_we,
   input  logic [31:0]   mem_rd_dout
);

   localparam logic [31:0] Nop = 32'h0000_0013;

   typedef enum logic [1:0] {StIdle, StLoad, StRun} state_t;

   state_t        state;
   logic [AW-1:0] idx;
   logic [AW:0]   remaining;
   logic [31:0]   csum;
   logic          done;

   logic          xfer;
   logic [AW:0]   len_eff;
   logic          run;

   assign run     = (state == StRun);
   assign xfer    = (state == StLoad) && load_valid;
   // A zero length requests a full-memory session.
   assign len_eff = (load_len == '0) ? (AW+1)'(DEPTH) : load_len;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= StIdle;
         idx       <= '0;
         remaining <= '0;
         csum      <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle, StRun: begin
               if (load_start) begin
                  state     <= StLoad;
                  remaining <= len_eff;
                  idx       <= '0;
                  csum      <= '0;
               end
            end
            StLoad: begin
               if (load_valid) begin
                  idx       <= idx + AW'(1);
                  remaining <= remaining - (AW+1)'(1);
                  csum      <= csum ^ load_data;
                  if (remaining == (AW+1)'(1)) begin
                     state <= StRun;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   always_comb begin
      mem_wr_addr = '0;
      if (xfer) mem_wr_addr[AW+1:0] = {idx, 2'b00};
   end

   assign mem_we      = xfer;
   assign mem_wr_din  = xfer ? load_data : '0;
   assign load_ready  = (state == StLoad);
   assign core_stall  = !run;
   assign fetch_valid = run;
   assign mem_rd_addr = run ? fetch_addr : '0;
   assign fetch_instr = run ? mem_rd_dout : Nop;
   assign load_done   = done;
   assign load_csum   = csum;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: write scoreboard fed at stimulus time and drained by a
// write monitor, plus immediate-assertion checks of status and fetch outputs.
module tb_imem_loader;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_start;
   logic [AW:0]   load_len;
   logic          load_valid;
   logic [31:0]   load_data;
   logic          load_ready;
   logic          load_done;
   logic [31:0]   load_csum;
   logic          core_stall;
   logic [31:0]   fetch_addr;
   logic [31:0]   fetch_instr;
   logic          fetch_valid;
   logic [31:0]   mem_rd_addr;
   logic [31:0]   mem_wr_addr;
   logic [31:0]   mem_wr_din;
   logic          mem_we;
   logic [31:0]   mem_rd_dout;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [63:0] exp_q[$];
   logic [31:0] mem [0:63];
   int          exp_idx;
   logic [31:0] exp_csum;

   always #5 clk = ~clk;

   imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .load_done(load_done), .load_csum(load_csum), .core_stall(core_stall),
      .fetch_addr(fetch_addr), .fetch_instr(fetch_instr), .fetch_valid(fetch_valid),
      .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_din(mem_wr_din),
      .mem_we(mem_we), .mem_rd_dout(mem_rd_dout)
   );

   // Behavioural 1R1W memory with combinational read.
   always @(posedge clk) if (mem_we) mem[mem_wr_addr[7:2]] <= mem_wr_din;
   assign mem_rd_dout = mem[mem_rd_addr[7:2]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Write monitor: every write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", mem_wr_addr, 32'hFFFF_FFFF);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("wr_addr", mem_wr_addr, e[63:32]);
            chk("wr_data", mem_wr_din, e[31:0]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_stalled(input string tag);
      @(negedge clk);
      chk({tag, "_stall"}, 32'(core_stall), 32'd1);
      chk({tag, "_fvalid"}, 32'(fetch_valid), 32'd0);
      chk({tag, "_finstr"}, fetch_instr, NOP);
      chk({tag, "_rdaddr"}, mem_rd_addr, 32'd0);
   endtask

   // Present one word in LOAD and record the write it must produce.
   task automatic send(input logic [31:0] d);
      load_valid = 1'b1;
      load_data  = d;
      exp_q.push_back({32'(exp_idx) << 2, d});
      exp_idx  = (exp_idx + 1) % DEPTH;
      exp_csum = exp_csum ^ d;
      step();
   endtask

   task automatic start(input logic [AW:0] len);
      load_start = 1'b1;
      load_len   = len;
      step();
      load_start = 1'b0;
      exp_idx    = 0;
      exp_csum   = '0;
   endtask

   initial begin
      rst = 1'b0; load_start = 1'b0; load_len = '0; load_valid = 1'b0;
      load_data = '0; fetch_addr = '0;

      // Reset state
      step(); step();
      chk_stalled("rst");
      chk("rst_ready", 32'(load_ready), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_done", 32'(load_done), 32'd0);
      chk("rst_csum", load_csum, 32'd0);
      chk("rst_wraddr", mem_wr_addr, 32'd0);
      step();
      rst = 1'b1;

      // Idle for 10 cycles with load_valid asserted: must not write or leave IDLE
      load_valid = 1'b1;
      load_data  = 32'hDEAD_BEEF;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_stall", 32'(core_stall), 32'd1);
         chk("idle_fvalid", 32'(fetch_valid), 32'd0);
         chk("idle_ready", 32'(load_ready), 32'd0);
         chk("idle_we", 32'(mem_we), 32'd0);
         step();
      end
      load_valid = 1'b0;

      // Three-word load with a valid gap; load_start on the final transfer is ignored
      start(3);
      chk_stalled("load");
      chk("load_ready", 32'(load_ready), 32'd1);
      chk("load_csum_clr", load_csum, 32'd0);
      send(32'hA5A5_A5A5);
      send(32'h0000_0013);
      load_valid = 1'b0;
      load_data  = 32'h1234_5678;
      @(negedge clk);
      chk("gap_we", 32'(mem_we), 32'd0);
      step();
      load_start = 1'b1;
      send(32'hFFFF_FFFF);
      load_start = 1'b0;
      load_valid = 1'b0;
      @(negedge clk);
      chk("run3_done", 32'(load_done), 32'd1);
      chk("run3_csum", load_csum, 32'h5A5A_5A49);
      chk("run3_model_csum", load_csum, exp_csum);
      chk("run3_fvalid", 32'(fetch_valid), 32'd1);
      chk("run3_stall", 32'(core_stall), 32'd0);
      chk("run3_ready", 32'(load_ready), 32'd0);
      step();

      // RUN fetch passthrough; load_valid in RUN has no effect
      fetch_addr = 32'h4;
      load_valid = 1'b1;
      load_data  = 32'hCAFE_F00D;
      @(negedge clk);
      chk("run_done_once", 32'(load_done), 32'd0);
      chk("run_rdaddr", mem_rd_addr, 32'h4);
      chk("run_finstr", fetch_instr, 32'h0000_0013);
      chk("run_fvalid", 32'(fetch_valid), 32'd1);
      step();
      fetch_addr = 32'h0;
      @(negedge clk);
      chk("run_finstr0", fetch_instr, 32'hA5A5_A5A5);
      chk("run_csum_hold", load_csum, 32'h5A5A_5A49);
      load_valid = 1'b0;

      // load_start in RUN: transition cycle is still RUN; full-depth session follows
      step();
      load_start = 1'b1;
      load_len   = '0;
      @(negedge clk);
      chk("rerun_fvalid", 32'(fetch_valid), 32'd1);
      step();
      exp_idx  = 0;
      exp_csum = '0;
      @(negedge clk);
      chk("reload_stall", 32'(core_stall), 32'd1);
      chk("reload_csum_clr", load_csum, 32'd0);
      chk("reload_ready", 32'(load_ready), 32'd1);
      // load_start stays high throughout LOAD and must be ignored
      for (int i = 0; i < DEPTH; i++) send($urandom());
      load_start = 1'b0;
      load_valid = 1'b1;
      load_data  = 32'h5555_AAAA;
      @(negedge clk);
      chk("full_done", 32'(load_done), 32'd1);
      chk("full_csum", load_csum, exp_csum);
      chk("full_fvalid", 32'(fetch_valid), 32'd1);
      step();
      @(negedge clk);
      chk("full_no_extra_we", 32'(mem_we), 32'd0);
      load_valid = 1'b0;

      // Reset mid-session after 2 of 5 words, with a word on offer in the reset cycle
      start(5);
      send(32'h1111_1111);
      send(32'h2222_2222);
      load_valid = 1'b1;
      load_data  = 32'h3333_3333;
      rst = 1'b0;
      chk_stalled("abort");
      chk("abort_we", 32'(mem_we), 32'd0);
      chk("abort_ready", 32'(load_ready), 32'd0);
      chk("abort_csum", load_csum, 32'd0);
      step();
      rst = 1'b1;
      load_valid = 1'b0;
      step();
      chk_stalled("post_abort_idle");
      step();
      start(1);
      send(32'h7777_0001);
      load_valid = 1'b0;
      @(negedge clk);
      chk("len1_done", 32'(load_done), 32'd1);
      chk("len1_csum", load_csum, 32'h7777_0001);
      fetch_addr = 32'h0;
      #1;
      chk("len1_fetch", fetch_instr, 32'h7777_0001);
      step();

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 16, instruction memory depth in 32-bit words; power of two, 2..64.
REQ-002 Parameter AW, default 4, word-index width; AW = log2(DEPTH).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low; synchronous deassert is provided externally.
REQ-005 load_start  in  1  request to begin a program-load session.
REQ-006 load_len  in  AW+1  words to load, sampled when load_start is accepted; 0 means DEPTH.
REQ-007 load_valid  in  1  load_data carries a valid word.
REQ-008 load_data  in  32  program word.
REQ-009 load_ready  out  1  loader accepts load_data this cycle.
REQ-010 load_done  out  1  one-cycle pulse after the last word of a session is written.
REQ-011 load_csum  out  32  XOR of all words written in the current or last session.
REQ-012 core_stall  out  1  holds the core's fetch and PC while the program is not runnable.
REQ-013 fetch_addr  in  32  core fetch byte address.
REQ-014 fetch_instr  out  32  instruction returned to the core.
REQ-015 fetch_valid  out  1  fetch_instr is valid this cycle.
REQ-016 mem_rd_addr, mem_wr_addr  out  32 each  byte addresses to the 1R1W instruction memory.
REQ-017 mem_wr_din  out  32  write data; mem_we  out  1  write enable.
REQ-018 mem_rd_dout  in  32  memory read data; combinational, valid in the same cycle as mem_rd_addr.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, LOAD and RUN.
REQ-020 IDLE: core_stall=1, fetch_valid=0, load_ready=0; load_start=1 -> LOAD.
REQ-021 On entering LOAD: latch load_len (0 -> DEPTH) into remaining count, clear word index to 0, clear load_csum to 0.
REQ-022 LOAD: load_ready=1, core_stall=1, fetch_valid=0.
REQ-023 LOAD handshake: a word transfers when load_valid & load_ready in the same cycle. Data is not required to be held when load_valid=0.
REQ-024 On each transfer, in the same cycle: mem_we=1, mem_wr_addr={index,2'b00} zero-extended to 32 bits, mem_wr_din=load_data.
REQ-025 On each transfer, at the next edge: index+1 (mod DEPTH), remaining-1, load_csum ^= load_data.
REQ-026 mem_we SHALL be 0 in every cycle without a transfer.
REQ-027 When the transfer of the final word occurs (remaining==1): next state is RUN and load_done=1 for exactly the first RUN cycle.
REQ-028 RUN: core_stall=0, load_ready=0, fetch_valid=1.
REQ-029 RUN: mem_rd_addr=fetch_addr and fetch_instr=mem_rd_dout, combinational, zero added latency.
REQ-030 RUN: load_start=1 -> LOAD; the transition cycle is still a RUN cycle with fetch_valid=1.
REQ-031 Outside RUN: fetch_instr=32'h00000013 (NOP) and mem_rd_addr=0.
REQ-032 load_start SHALL be ignored in LOAD, including a load_start that coincides with the final transfer.
REQ-033 load_valid SHALL be ignored in IDLE and RUN: no write, no counter change.
REQ-034 Word-index wrap: when index reaches DEPTH-1, the next transfer writes word DEPTH-1 and index becomes 0. With load_len=0 the session writes words 0..DEPTH-1 exactly once.
REQ-035 load_csum SHALL hold its value in RUN and IDLE until the next LOAD entry.

Reset
REQ-036 While rst=0: state=IDLE, index=0, remaining=0, load_csum=0, load_done=0, load_ready=0, mem_we=0, core_stall=1, fetch_valid=0, fetch_instr=NOP, and all address outputs 0.
REQ-037 Reset during LOAD SHALL abort the session with no write in the reset cycle. Memory contents are not cleared by this block.
REQ-038 After rst deasserts, the block SHALL stay in IDLE until load_start=1.

Verification
REQ-039 Reset then idle: core_stall=1, fetch_valid=0, load_ready=0, mem_we=0 for 10 cycles.
REQ-040 Load 3 words (A5A5A5A5, 00000013, FFFFFFFF), with a load_valid gap between words 2 and 3 -> writes to byte addresses 0x0, 0x4, 0x8; load_csum=5A5A5A49; load_done pulses once; RUN entered on the next cycle.
REQ-041 In RUN with fetch_addr=0x4 -> mem_rd_addr=0x4, fetch_instr=00000013 in the same cycle, fetch_valid=1.
REQ-042 load_len=0, DEPTH=16, 16 back-to-back words -> addresses 0x00..0x3C in order; no write after the 16th; index returns to 0.
REQ-043 rst asserted after 2 of 5 words -> IDLE with counters cleared; a following load_start with load_len=1 writes address 0x0.
REQ-044 load_start in RUN -> LOAD on the next cycle, core_stall=1, load_csum cleared; load_start during LOAD, and load_valid in RUN -> no effect.
